alu_request_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests (A, B, FunSel, WF) from two clients and grants the ALU round-robin. It drives the ALU operand and function inputs, waits the ALU's fixed registered latency, then returns the captured ALUOut and FlagsOut to the granted client with a one-cycle Done pulse. It sits between the control unit's datapath clients and the single ALU instance.

---
 rtl/alu_request_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency ALU between two clients.
// Optional ALU_ARB_LOCK_EN adds a Lock port that lets the last winner keep priority for the next tie.
//
// state  | meaning
// IDLE   | waiting for any Req; arbitrates and latches operands on the grant edge
// ISSUE  | Gnt pulse; the edge ending this state is when the ALU samples its operands
// WAIT   | counting down the ALU latency; captures AluOut/AluFlags when the count hits 0
// DONE   | Done pulse for the winner; Result/Flags are valid
module alu_request_arbiter #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  Req,
`ifdef ALU_ARB_LOCK_EN
    input  logic [1:0]  Lock,
`endif
    input  logic [63:0] OpA,
    input  logic [63:0] OpB,
    input  logic [9:0]  OpFunSel,
    input  logic [1:0]  OpWF,
    output logic [1:0]  Gnt,
    output logic [1:0]  Done,
    output logic [31:0] Result,
    output logic [3:0]  Flags,
    output logic        Busy,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        win_q, win_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_fs_q, alu_fs_d;
    logic        alu_wf_q, alu_wf_d;

    logic req_win;
    logic lock_hit;

    // A lone requester wins; on a tie the client that did not win last time wins.
    always_comb begin
        if (Req == 2'b10)
            req_win = 1'b1;
        else if (Req == 2'b01)
            req_win = 1'b0;
        else
            req_win = ~last_q;
    end

`ifdef ALU_ARB_LOCK_EN
    assign lock_hit = Lock[win_q];
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        result_d = result_q;
        flags_d  = flags_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_fs_d = alu_fs_q;
        alu_wf_d = alu_wf_q;
        case (state_q)
            S_IDLE: begin
                if (|Req) begin
                    win_d    = req_win;
                    last_d   = req_win;
                    alu_a_d  = req_win ? OpA[63:32] : OpA[31:0];
                    alu_b_d  = req_win ? OpB[63:32] : OpB[31:0];
                    alu_fs_d = req_win ? OpFunSel[9:5] : OpFunSel[4:0];
                    alu_wf_d = req_win ? OpWF[1] : OpWF[0];
                    cnt_d    = LAT_CNT;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    result_d = AluOut;
                    flags_d  = AluFlags;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // A locked winner hands itself priority for the next tie.
                if (lock_hit)
                    last_d = ~win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
            alu_a_q  <= 32'd0;
            alu_b_q  <= 32'd0;
            alu_fs_q <= 5'd0;
            alu_wf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_fs_q <= alu_fs_d;
            alu_wf_q <= alu_wf_d;
        end
    end

    assign Gnt       = (state_q == S_ISSUE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign Done      = (state_q == S_DONE)  ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign Busy      = (state_q != S_IDLE);
    assign Result    = result_q;
    assign Flags     = flags_q;
    assign AluA      = alu_a_q;
    assign AluB      = alu_b_q;
    assign AluFunSel = alu_fs_q;
    assign AluWF     = alu_wf_q;

endmodule
